// File: rtl/a5_pkg.sv
// Shared constants, burst tags and FSM state encoding for the A5/1 keystream buffer.
package a5_pkg;
   localparam int A5_KEY_BITS   = 64;
   localparam int A5_FRAME_BITS = 22;
   localparam int A5_BURST_BITS = 114;

   localparam logic BURST_DL = 1'b0;
   localparam logic BURST_UL = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      WARMUP,
      DL,
      UL,
      DONE
   } a5_state_e;
endpackage

// File: rtl/A5Generator.sv
// A5/1 serial keystream generator: key/frame setup, 100+1 mixing clocks, then one bit per
// unstalled cycle while valid. Key and frame bits are loaded LSB first.
module A5Generator
   import a5_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     stall,
   input  logic [A5_KEY_BITS-1:0]   key,
   input  logic [A5_FRAME_BITS-1:0] frame,
   output logic                     ks_bit,
   output logic                     valid
);
   localparam int SETUP = A5_KEY_BITS + A5_FRAME_BITS;
   // One extra mixing clock so the first presented bit follows a clock, as in the reference.
   localparam int READY = SETUP + 101;

   logic [18:0]              r1_q, r1_d;
   logic [21:0]              r2_q, r2_d;
   logic [22:0]              r3_q, r3_d;
   logic [7:0]               cnt_q, cnt_d;
   logic                     active_q, active_d;
   logic [A5_KEY_BITS-1:0]   key_q, key_d;
   logic [A5_FRAME_BITS-1:0] frame_q, frame_d;
   logic [31:0]              frame_ext;
   logic [4:0]               fidx;
   logic                     fb1, fb2, fb3, maj, inb;

   always_comb begin
      r1_d      = r1_q;
      r2_d      = r2_q;
      r3_d      = r3_q;
      cnt_d     = cnt_q;
      active_d  = active_q;
      key_d     = key_q;
      frame_d   = frame_q;
      fb1       = r1_q[13] ^ r1_q[16] ^ r1_q[17] ^ r1_q[18];
      fb2       = r2_q[20] ^ r2_q[21];
      fb3       = r3_q[7] ^ r3_q[20] ^ r3_q[21] ^ r3_q[22];
      maj       = (r1_q[8] & r2_q[10]) | (r1_q[8] & r3_q[10]) | (r2_q[10] & r3_q[10]);
      frame_ext = {{(32-A5_FRAME_BITS){1'b0}}, frame_q};
      fidx      = 5'(cnt_q - 8'(A5_KEY_BITS));
      inb       = (cnt_q < 8'(A5_KEY_BITS)) ? key_q[cnt_q[5:0]] : frame_ext[fidx];
      if (start) begin
         r1_d     = '0;
         r2_d     = '0;
         r3_d     = '0;
         cnt_d    = '0;
         active_d = 1'b1;
         key_d    = key;
         frame_d  = frame;
      end else if (active_q) begin
         if (cnt_q < 8'(SETUP)) begin
            r1_d  = {r1_q[17:0], fb1 ^ inb};
            r2_d  = {r2_q[20:0], fb2 ^ inb};
            r3_d  = {r3_q[21:0], fb3 ^ inb};
            cnt_d = cnt_q + 8'd1;
         end else if ((cnt_q < 8'(READY)) || !stall) begin
            if (r1_q[8] == maj)  r1_d = {r1_q[17:0], fb1};
            if (r2_q[10] == maj) r2_d = {r2_q[20:0], fb2};
            if (r3_q[10] == maj) r3_d = {r3_q[21:0], fb3};
            if (cnt_q < 8'(READY)) cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_q     <= '0;
         r2_q     <= '0;
         r3_q     <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
         key_q    <= '0;
         frame_q  <= '0;
      end else begin
         r1_q     <= r1_d;
         r2_q     <= r2_d;
         r3_q     <= r3_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
         key_q    <= key_d;
         frame_q  <= frame_d;
      end
   end

   assign ks_bit = r1_q[18] ^ r2_q[21] ^ r3_q[22];
   assign valid  = active_q && (cnt_q == 8'(READY));
endmodule

// File: rtl/Fifo.sv
// Synchronous FIFO with flush, combinational head read and simultaneous read/write when full.
module Fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    cnt_q, cnt_d;
   logic             rd_ok, wr_ok;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == LW'(DEPTH));
   assign level = cnt_q;
   assign rd_ok = rd_en & ~empty;
   assign wr_ok = wr_en & (~full | rd_ok);
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         if (wr_ok && !flush) mem_q[wr_ptr_q] <= wr_data;
      end
   end
endmodule

// File: rtl/a5_word_packer.sv
// Serial-to-word packer: first bit in bit 0, a word closes when full or at end of burst,
// and the completed word with its tags is presented with push one cycle later.
module a5_word_packer
   import a5_pkg::*;
#(
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  bit_vld,
   input  logic                  bit_in,
   input  logic                  eob,
   input  logic                  burst_in,
   output logic [WORD_WIDTH-1:0] word_out,
   output logic                  last_out,
   output logic                  burst_out,
   output logic                  push
);
   localparam int IDX_W = $clog2(WORD_WIDTH);

   logic [WORD_WIDTH-1:0] acc_q, acc_d, acc_nxt, word_q, word_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  last_q, last_d, burst_q, burst_d, push_q, push_d;

   always_comb begin
      acc_d   = acc_q;
      idx_d   = idx_q;
      word_d  = word_q;
      last_d  = last_q;
      burst_d = burst_q;
      push_d  = 1'b0;
      acc_nxt = acc_q | ({{(WORD_WIDTH-1){1'b0}}, bit_in} << idx_q);
      if (flush) begin
         acc_d   = '0;
         idx_d   = '0;
         word_d  = '0;
         last_d  = 1'b0;
         burst_d = BURST_DL;
      end else if (bit_vld) begin
         if ((idx_q == IDX_W'(WORD_WIDTH-1)) || eob) begin
            // Unfilled MSBs of a short final word stay zero because acc restarts cleared.
            word_d  = acc_nxt;
            last_d  = eob;
            burst_d = burst_in;
            push_d  = 1'b1;
            acc_d   = '0;
            idx_d   = '0;
         end else begin
            acc_d = acc_nxt;
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         idx_q   <= '0;
         word_q  <= '0;
         last_q  <= 1'b0;
         burst_q <= BURST_DL;
         push_q  <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         last_q  <= last_d;
         burst_q <= burst_d;
         push_q  <= push_d;
      end
   end

   assign word_out  = word_q;
   assign last_out  = last_q;
   assign burst_out = burst_q;
   assign push      = push_q;
endmodule

// File: rtl/a5_keystream_buffer.sv
// A5/1 keystream buffer: frames 2x BURST_BITS keystream into tagged words in a FIFO.
// Optional A5_KEYSTREAM_BUFFER_AUTO_FRAME_EN: auto-increment frame and restart after each frame.
module a5_keystream_buffer
   import a5_pkg::*;
#(
   parameter int WORD_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int BURST_BITS = A5_BURST_BITS
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            load,
   input  logic [A5_KEY_BITS-1:0]          key,
   input  logic [A5_FRAME_BITS-1:0]        frame,
   input  logic                            rd_en,
   output logic [WORD_WIDTH-1:0]           data_out,
   output logic                            data_burst,
   output logic                            data_last,
   output logic                            empty,
   output logic                            full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
   output logic                            busy,
   output logic                            done
);
   localparam int CNT_W = $clog2(BURST_BITS);

   a5_state_e                state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     gen_start, gen_stall, gen_bit, gen_valid;
   logic                     consume, eob, burst_tag;
   logic [A5_KEY_BITS-1:0]   gen_key;
   logic [A5_FRAME_BITS-1:0] gen_frame;
   logic [WORD_WIDTH-1:0]    pk_word;
   logic                     pk_push, pk_last, pk_burst;
   logic [WORD_WIDTH+1:0]    fifo_rd;
`ifdef A5_KEYSTREAM_BUFFER_AUTO_FRAME_EN
   logic [A5_KEY_BITS-1:0]   key_q, key_d;
   logic [A5_FRAME_BITS-1:0] frame_q, frame_d;
   logic                     done_q, done_d;
`endif

   // The push cycle stalls too, so a word never arrives while the FIFO is full.
   assign gen_stall = full | pk_push | (state_q == IDLE) | (state_q == DONE);
   assign consume   = gen_valid & ~gen_stall & ~load;
   assign eob       = (cnt_q == CNT_W'(BURST_BITS-1));
   assign burst_tag = (state_q == UL) ? BURST_UL : BURST_DL;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gen_start = 1'b0;
      gen_key   = key;
      gen_frame = frame;
`ifdef A5_KEYSTREAM_BUFFER_AUTO_FRAME_EN
      key_d     = key_q;
      frame_d   = frame_q;
`endif
      if (load) begin
         state_d   = WARMUP;
         cnt_d     = '0;
         gen_start = 1'b1;
`ifdef A5_KEYSTREAM_BUFFER_AUTO_FRAME_EN
         key_d     = key;
         frame_d   = frame;
`endif
      end else begin
         if (consume) cnt_d = eob ? '0 : cnt_q + 1'b1;
         case (state_q)
            WARMUP: if (gen_valid) state_d = WARMUP == WARMUP ? DL : DL;
            DL:     if (consume && eob) state_d = UL;
            UL:     if (pk_push && pk_last && (pk_burst == BURST_UL)) state_d = DONE;
            DONE: begin
`ifdef A5_KEYSTREAM_BUFFER_AUTO_FRAME_EN
               if (!full) begin
                  state_d   = WARMUP;
                  cnt_d     = '0;
                  gen_start = 1'b1;
                  gen_key   = key_q;
                  gen_frame = frame_q + 1'b1;
                  frame_d   = frame_q + 1'b1;
               end
`endif
            end
            default: state_d = state_q;
         endcase
      end
`ifdef A5_KEYSTREAM_BUFFER_AUTO_FRAME_EN
      done_d = (state_d == DONE) && (state_q != DONE);
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
`ifdef A5_KEYSTREAM_BUFFER_AUTO_FRAME_EN
         key_q   <= '0;
         frame_q <= '0;
         done_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
`ifdef A5_KEYSTREAM_BUFFER_AUTO_FRAME_EN
         key_q   <= key_d;
         frame_q <= frame_d;
         done_q  <= done_d;
`endif
      end
   end

   A5Generator u_gen (
      .clk    (clk),
      .rst_n  (reset_n),
      .start  (gen_start),
      .stall  (gen_stall),
      .key    (gen_key),
      .frame  (gen_frame),
      .ks_bit (gen_bit),
      .valid  (gen_valid)
   );

   a5_word_packer #(.WORD_WIDTH(WORD_WIDTH)) u_packer (
      .clk       (clk),
      .rst_n     (reset_n),
      .flush     (load),
      .bit_vld   (consume),
      .bit_in    (gen_bit),
      .eob       (eob),
      .burst_in  (burst_tag),
      .word_out  (pk_word),
      .last_out  (pk_last),
      .burst_out (pk_burst),
      .push      (pk_push)
   );

   Fifo #(.WIDTH(WORD_WIDTH+2), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .flush   (load),
      .wr_en   (pk_push),
      .wr_data ({pk_burst, pk_last, pk_word}),
      .rd_en   (rd_en),
      .rd_data (fifo_rd),
      .empty   (empty),
      .full    (full),
      .level   (level)
   );

   assign data_out   = fifo_rd[WORD_WIDTH-1:0];
   assign data_last  = fifo_rd[WORD_WIDTH];
   assign data_burst = fifo_rd[WORD_WIDTH+1];
   assign busy       = (state_q == WARMUP) || (state_q == DL) || (state_q == UL);
`ifdef A5_KEYSTREAM_BUFFER_AUTO_FRAME_EN
   assign done = done_q;
`else
   assign done = (state_q == DONE);
`endif
endmodule

// File: tb/tb_a5_keystream_buffer.sv
// Self-checking bench for a5_keystream_buffer at WORD_WIDTH 32, 16 and 8 against a bit-level A5/1 model.
module tb_a5_keystream_buffer;
   localparam int BB = 114;

   logic        clk = 1'b0;
   logic        reset_n, load, rd32, rd16, rd8;
   logic [63:0] key;
   logic [21:0] frame;
   logic [31:0] d32;
   logic [15:0] d16;
   logic [7:0]  d8;
   logic        b32, l32, e32, f32, bz32, dn32;
   logic        b16, l16, e16, f16, bz16, dn16;
   logic        b8, l8, e8, f8, bz8, dn8;
   logic [2:0]  lv32, lv16, lv8;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   logic [33:0] q32[$], q16[$], q8[$];
   bit rr[3][23];

   always #5 clk = ~clk;

   a5_keystream_buffer #(.WORD_WIDTH(32)) dut32 (.clk(clk), .reset_n(reset_n), .load(load), .key(key),
      .frame(frame), .rd_en(rd32), .data_out(d32), .data_burst(b32), .data_last(l32), .empty(e32),
      .full(f32), .level(lv32), .busy(bz32), .done(dn32));
   a5_keystream_buffer #(.WORD_WIDTH(16)) dut16 (.clk(clk), .reset_n(reset_n), .load(load), .key(key),
      .frame(frame), .rd_en(rd16), .data_out(d16), .data_burst(b16), .data_last(l16), .empty(e16),
      .full(f16), .level(lv16), .busy(bz16), .done(dn16));
   a5_keystream_buffer #(.WORD_WIDTH(8)) dut8 (.clk(clk), .reset_n(reset_n), .load(load), .key(key),
      .frame(frame), .rd_en(rd8), .data_out(d8), .data_burst(b8), .data_last(l8), .empty(e8),
      .full(f8), .level(lv8), .busy(bz8), .done(dn8));

   // Reference A5/1: registers as bit arrays, shifted toward higher index, feedback into bit 0.
   function automatic void clk_regs(input bit [2:0] en, input bit inb);
      int len[3];
      bit fb;
      len = '{19, 22, 23};
      for (int i = 0; i < 3; i++) if (en[i]) begin
         case (i)
            0:       fb = rr[0][13] ^ rr[0][16] ^ rr[0][17] ^ rr[0][18];
            1:       fb = rr[1][20] ^ rr[1][21];
            default: fb = rr[2][7] ^ rr[2][20] ^ rr[2][21] ^ rr[2][22];
         endcase
         for (int p = len[i] - 1; p > 0; p--) rr[i][p] = rr[i][p-1];
         rr[i][0] = fb ^ inb;
      end
   endfunction

   function automatic logic [227:0] ks_ref(input logic [63:0] k, input logic [21:0] f);
      logic [227:0] ks;
      bit maj;
      bit [2:0] en;
      ks = '0;
      for (int i = 0; i < 3; i++) for (int p = 0; p < 23; p++) rr[i][p] = 1'b0;
      for (int s = 0; s < 86; s++) clk_regs(3'b111, (s < 64) ? k[s] : f[s-64]);
      for (int s = 0; s < 100 + 228; s++) begin
         maj = (int'(rr[0][8]) + int'(rr[1][10]) + int'(rr[2][10])) >= 2;
         en  = {rr[2][10] == maj, rr[1][10] == maj, rr[0][8] == maj};
         clk_regs(en, 1'b0);
         if (s >= 100) ks[s-100] = rr[0][18] ^ rr[1][21] ^ rr[2][22];
      end
      return ks;
   endfunction

   // Expected {burst, last, word} for global word index gi of a frame at width w.
   function automatic logic [33:0] exp_word(input logic [227:0] ks, input int w, input int gi);
      int nw, b, j, idx;
      logic [31:0] wd;
      nw = (BB + w - 1) / w;
      b  = gi / nw;
      j  = gi % nw;
      wd = '0;
      for (int k = 0; k < w; k++) begin
         idx = j * w + k;
         if (idx < BB) wd[k] = ks[b*BB + idx];
      end
      return {b[0], (j == nw - 1), wd};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [63:0] k, input logic [21:0] f);
      key = k;
      frame = f;
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic drain_all(input int n32, input int n16, input int n8, input bit rnd, input int budget);
      int cyc = 0;
      q32.delete(); q16.delete(); q8.delete();
      while ((q32.size() < n32 || q16.size() < n16 || q8.size() < n8) && cyc < budget) begin
         rd32 = 0; rd16 = 0; rd8 = 0;
         if (q32.size() < n32 && !e32 && (!rnd || $urandom_range(1, 0) == 1)) begin
            q32.push_back({b32, l32, d32}); rd32 = 1;
         end
         if (q16.size() < n16 && !e16 && (!rnd || $urandom_range(1, 0) == 1)) begin
            q16.push_back({b16, l16, 16'h0, d16}); rd16 = 1;
         end
         if (q8.size() < n8 && !e8 && (!rnd || $urandom_range(1, 0) == 1)) begin
            q8.push_back({b8, l8, 24'h0, d8}); rd8 = 1;
         end
         tick();
         cyc++;
         if (dn32) done_cnt++;
      end
      rd32 = 0; rd16 = 0; rd8 = 0;
      checks++;
      if (cyc >= budget) begin
         failures++;
         $display("FAIL drain_timeout got=%0d/%0d/%0d words exp=%0d/%0d/%0d", q32.size(), q16.size(), q8.size(), n32, n16, n8);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; load = 1'b0; rd32 = 0; rd16 = 0; rd8 = 0; key = '0; frame = '0;
      repeat (3) tick();
      checks++; if (bz32 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bz32); end
      checks++; if (dn32 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", dn32); end
      checks++; if (e32 !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", e32); end
      checks++; if (f32 !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", f32); end
      checks++; if (lv32 !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", lv32); end
      checks++; if ({b32, l32, d32} !== 34'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {b32, l32, d32}); end
      @(negedge clk) reset_n = 1'b1;
      tick();
      checks++; if (e8 !== 1'b1 || bz8 !== 1'b0) begin failures++; $display("FAIL reset_w8 got=%b%b exp=10", e8, bz8); end
   endtask

   task automatic test_stream();
      logic [227:0] ks;
      ks = ks_ref(64'h0123456789ABCDEF, 22'h134);
      do_load(64'h0123456789ABCDEF, 22'h134);
      drain_all(8, 16, 30, 1'b0, 3000);
      checks++; if (q32.size() != 8) begin failures++; $display("FAIL stream_count32 got=%0d exp=8", q32.size()); end
      for (int j = 0; j < q32.size(); j++) begin
         checks++;
         if (q32[j] !== exp_word(ks, 32, j)) begin failures++; $display("FAIL stream_w32 word=%0d got=%h exp=%h", j, q32[j], exp_word(ks, 32, j)); end
      end
      if (q32.size() == 8) begin
         checks++; if (q32[3][31:18] !== 14'h0 || q32[7][31:18] !== 14'h0) begin failures++; $display("FAIL stream_pad got=%h/%h exp=0", q32[3][31:18], q32[7][31:18]); end
         checks++; if ({q32[3][32], q32[7][32], q32[2][32]} !== 3'b110) begin failures++; $display("FAIL stream_last got=%b exp=110", {q32[3][32], q32[7][32], q32[2][32]}); end
      end
      for (int j = 0; j < q16.size(); j++) begin
         checks++;
         if (q16[j] !== exp_word(ks, 16, j)) begin failures++; $display("FAIL stream_w16 word=%0d got=%h exp=%h", j, q16[j], exp_word(ks, 16, j)); end
      end
      for (int j = 0; j < q8.size(); j++) begin
         checks++;
         if (q8[j] !== exp_word(ks, 8, j)) begin failures++; $display("FAIL stream_w8 word=%0d got=%h exp=%h", j, q8[j], exp_word(ks, 8, j)); end
      end
`ifndef A5_KEYSTREAM_BUFFER_AUTO_FRAME_EN
      repeat (5) tick();
      checks++; if (dn32 !== 1'b1 || bz32 !== 1'b0) begin failures++; $display("FAIL stream_done got=%b%b exp=10", dn32, bz32); end
`endif
   endtask

   task automatic test_backpressure();
      logic [227:0] ks;
      int wait_c;
      ks = ks_ref(64'h0123456789ABCDEF, 22'h134);
      do_load(64'h0123456789ABCDEF, 22'h134);
      repeat (700) tick();
      checks++; if (f32 !== 1'b1 || lv32 !== 3'd4) begin failures++; $display("FAIL bp_full got=%b lvl=%0d exp=1 lvl=4", f32, lv32); end
      checks++; if (bz32 !== 1'b1) begin failures++; $display("FAIL bp_busy got=%b exp=1", bz32); end
      checks++; if (f8 !== 1'b1 || lv8 !== 3'd4) begin failures++; $display("FAIL bp_full8 got=%b lvl=%0d exp=1 lvl=4", f8, lv8); end
      q32.delete();
      for (int w = 0; w < 8; w++) begin
         wait_c = 0;
         while (e32 && wait_c < 2000) begin tick(); wait_c++; end
         if (e32) break;
         q32.push_back({b32, l32, d32});
         rd32 = 1; tick(); rd32 = 0;
         repeat (49) tick();
      end
      checks++; if (q32.size() != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", q32.size()); end
      for (int j = 0; j < q32.size(); j++) begin
         checks++;
         if (q32[j] !== exp_word(ks, 32, j)) begin failures++; $display("FAIL bp_word word=%0d got=%h exp=%h", j, q32[j], exp_word(ks, 32, j)); end
      end
   endtask

   task automatic test_reload();
      logic [63:0] k2;
      logic [21:0] f2;
      logic [227:0] ks;
      int wait_c = 0;
      k2 = {$urandom, $urandom};
      f2 = 22'($urandom);
      ks = ks_ref(k2, f2);
      do_load({$urandom, $urandom}, 22'($urandom));
      while (lv32 != 3'd2 && wait_c < 1000) begin tick(); wait_c++; end
      checks++; if (lv32 !== 3'd2) begin failures++; $display("FAIL reload_wait got=%0d exp=2", lv32); end
      do_load(k2, f2);
      checks++; if ({e32, e16, e8} !== 3'b111 || lv32 !== 3'd0) begin failures++; $display("FAIL reload_flush got=%b lvl=%0d exp=111 lvl=0", {e32, e16, e8}, lv32); end
      drain_all(8, 16, 30, 1'b1, 4000);
      for (int j = 0; j < q32.size(); j++) begin
         checks++;
         if (q32[j] !== exp_word(ks, 32, j)) begin failures++; $display("FAIL reload_w32 word=%0d got=%h exp=%h", j, q32[j], exp_word(ks, 32, j)); end
      end
      for (int j = 0; j < q8.size(); j++) begin
         checks++;
         if (q8[j] !== exp_word(ks, 8, j)) begin failures++; $display("FAIL reload_w8 word=%0d got=%h exp=%h", j, q8[j], exp_word(ks, 8, j)); end
      end
   endtask

   task automatic test_random();
      logic [63:0] k;
      logic [21:0] f;
      logic [227:0] ks;
      for (int it = 0; it < 2; it++) begin
         k = {$urandom, $urandom};
         f = 22'($urandom);
         ks = ks_ref(k, f);
         do_load(k, f);
         drain_all(8, 16, 30, 1'b1, 4000);
         for (int j = 0; j < q32.size(); j++) begin
            checks++;
            if (q32[j] !== exp_word(ks, 32, j)) begin failures++; $display("FAIL rand_w32 it=%0d word=%0d got=%h exp=%h", it, j, q32[j], exp_word(ks, 32, j)); end
         end
         for (int j = 0; j < q16.size(); j++) begin
            checks++;
            if (q16[j] !== exp_word(ks, 16, j)) begin failures++; $display("FAIL rand_w16 it=%0d word=%0d got=%h exp=%h", it, j, q16[j], exp_word(ks, 16, j)); end
         end
      end
   endtask

   task automatic test_reset_mid_ul();
      do_load({$urandom, $urandom}, 22'($urandom));
      drain_all(5, 0, 0, 1'b0, 3000);
      checks++; if (bz32 !== 1'b1) begin failures++; $display("FAIL midul_busy got=%b exp=1", bz32); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if ({bz32, dn32, e32, f32} !== 4'b0010 || lv32 !== 3'd0) begin failures++; $display("FAIL midul_async got=%b lvl=%0d exp=0010 lvl=0", {bz32, dn32, e32, f32}, lv32); end
      checks++; if ({b32, l32, d32} !== 34'h0 || e16 !== 1'b1) begin failures++; $display("FAIL midul_data got=%h e16=%b exp=0 e16=1", {b32, l32, d32}, e16); end
      @(negedge clk) reset_n = 1'b1;
      repeat (400) tick();
      checks++; if ({bz32, dn32, e32} !== 3'b001 || lv32 !== 3'd0) begin failures++; $display("FAIL midul_idle got=%b lvl=%0d exp=001 lvl=0", {bz32, dn32, e32}, lv32); end
   endtask

`ifdef A5_KEYSTREAM_BUFFER_AUTO_FRAME_EN
   task automatic test_auto_frame();
      logic [227:0] ksa, ksb;
      ksa = ks_ref(64'h0123456789ABCDEF, 22'h3FFFFF);
      ksb = ks_ref(64'h0123456789ABCDEF, 22'h000000);
      done_cnt = 0;
      do_load(64'h0123456789ABCDEF, 22'h3FFFFF);
      drain_all(16, 0, 0, 1'b0, 6000);
      for (int t = 0; t < 20; t++) begin tick(); if (dn32) done_cnt++; end
      checks++; if (q32.size() != 16) begin failures++; $display("FAIL auto_count got=%0d exp=16", q32.size()); end
      for (int j = 0; j < q32.size(); j++) begin
         checks++;
         if (q32[j] !== exp_word((j < 8) ? ksa : ksb, 32, j % 8)) begin
            failures++; $display("FAIL auto_word word=%0d got=%h exp=%h", j, q32[j], exp_word((j < 8) ? ksa : ksb, 32, j % 8));
         end
      end
      checks++; if (done_cnt != 2) begin failures++; $display("FAIL auto_done_pulses got=%0d exp=2", done_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_reload();
      test_random();
      test_reset_mid_ul();
`ifdef A5_KEYSTREAM_BUFFER_AUTO_FRAME_EN
      test_auto_frame();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
